// File: rtl/irq_encoder_8_3.sv
// 8-to-3 priority interrupt encoder: synchronizes active-low requests, latches
// falling edges into a pending register and presents the top enabled request over an irq/ack handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no request presented; waiting for an enabled pending bit
// ASSERT  | irq=1, code frozen; waiting for ack to go high
// RELEASE | serviced bit cleared, irq=0; waiting for ack to go low

module irq_encoder_8_3 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_n,
    input  logic       mask_we,
    input  logic [7:0] mask_in,
    input  logic       ack,
    output logic       irq,
    output logic [2:0] code,
    output logic [7:0] pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [2:0] ARM_INIT = 3'(SYNC_STAGES + 1);

    state_t                      state;
    state_t                      state_next;
    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0]                  req_sync;
    logic [7:0]                  prev_q;
    logic [7:0]                  mask;
    logic [2:0]                  arm_cnt;
    logic                        armed;
    logic [7:0]                  fall;
    logic [7:0]                  eligible;
    logic [2:0]                  top_idx;
    logic [7:0]                  clr;
    logic [7:0]                  pending_next;
    logic                        irq_next;
    logic [2:0]                  code_next;

    assign req_sync = sync_q[SYNC_STAGES-1];

    // Edge detection stays disarmed until prev_q holds a real sample, so a line
    // already low when reset is released is seen as steady, not as a new request.
    assign armed    = (arm_cnt == 3'd0);
    assign fall     = prev_q & ~req_sync & {8{armed}};
    assign eligible = pending & mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{8'hFF}};
            prev_q  <= 8'hFF;
            arm_cnt <= ARM_INIT;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], req_n};
            prev_q  <= req_sync;
            if (!armed) begin
                arm_cnt <= arm_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= 8'hFF;
        end else if (mask_we) begin
            mask <= mask_in;
        end
    end

    always_comb begin
        top_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (eligible[i]) begin
                top_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            irq     <= 1'b0;
            code    <= 3'd0;
            pending <= 8'h00;
        end else begin
            state   <= state_next;
            irq     <= irq_next;
            code    <= code_next;
            pending <= pending_next;
        end
    end

    always_comb begin
        state_next = state;
        irq_next   = irq;
        code_next  = code;
        clr        = 8'h00;
        case (state)
            IDLE: begin
                irq_next = 1'b0;
                if (|eligible) begin
                    code_next  = top_idx;
                    irq_next   = 1'b1;
                    state_next = ASSERT;
                end
            end
            ASSERT: begin
                irq_next = 1'b1;
                if (ack) begin
                    clr        = 8'h01 << code;
                    irq_next   = 1'b0;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                irq_next = 1'b0;
                if (!ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                irq_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
        // A fresh edge on the bit being serviced wins over its clear.
        pending_next = (pending & ~clr) | fall;
    end

endmodule

// File: doc/irq_encoder_8_3.md
Name: irq_encoder_8_3

Overview:
- 8-to-3 priority interrupt encoder for the register/control section. It is the encoder-side counterpart to the 3-8 select decoder, in the style of a DM74LS148.
- Samples eight asynchronous active-low request lines, latches edges into a pending register and applies an enable mask.
- Presents the highest-priority enabled request as a 3-bit code to the CPU control FSM.
- Holds the code stable across a four-phase irq/ack handshake, then clears the serviced bit.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per request line (legal range 2-3).

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_n  in  8  active-low request lines, asynchronous to clk; bit 7 is highest priority
- mask_we  in  1  when 1, mask register loads mask_in on the next clock edge
- mask_in  in  8  new enable mask; 1 = request enabled
- ack  in  1  acknowledge from CPU, four-phase handshake
- irq  out  1  interrupt request; 1 = code is valid
- code  out  3  index of the request being presented (7..0)
- pending  out  8  raw pending register, unmasked

Behaviour:
- Reset (rst_n=0, asynchronous):
  - irq=0, code=0, pending=0, mask=8'hFF.
  - Synchronizer flops and previous-sample flops = 8'hFF (inactive).
  - FSM goes to IDLE.
  - Assertion mid-handshake aborts the handshake; no bit survives.
- Synchronizer: each req_n bit passes through SYNC_STAGES flops. Only the synchronized value is used downstream.
- Edge capture:
  - Falling edge of synchronized req_n[i] (prev=1, now=0) sets pending[i].
  - A held-low line sets pending only once; a new falling edge is needed to re-request.
- Latency: a req_n falling edge that meets setup sets pending after SYNC_STAGES+1 rising edges.
- Mask: mask_we=1 loads mask_in. Masking a bit does not clear its pending bit; unmasking a pending bit makes it eligible again.
- FSM states IDLE, ASSERT, RELEASE:
  - IDLE:
    - If (pending & mask) != 0: code <= index of the highest set bit of (pending & mask), irq <= 1, go to ASSERT. irq rises 1 cycle after the qualifying pending bit.
    - ack is ignored in IDLE.
  - ASSERT:
    - irq=1; code is frozen. A later higher-priority request and mask changes do not alter code or drop irq.
    - On ack=1: pending[code] <= 0, irq <= 0, go to RELEASE.
  - RELEASE:
    - irq=0; code holds its last value.
    - When ack=0, go to IDLE. The earliest next irq is 1 cycle after that.
    - If ack is held high, no new irq is raised.
- Simultaneous events:
  - A new falling edge on bit i in the same cycle that ack clears pending[i]: set wins, and pending[i] stays 1.
  - Edges on other bits are unaffected by the clear.
- Priority: strict, fixed. Bit 7 is highest, bit 0 lowest; no rotation.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset with req_n=8'hFF, then release rst_n -> irq=0, code=0, pending=0 held for 10 cycles.
2. Drive req_n[5]=0 -> pending=8'h20 at cycle SYNC_STAGES+1 and irq=1, code=5 one cycle later. Then ack=1 -> next cycle irq=0, pending=0. Then ack=0 -> FSM in IDLE; with req_n still held low, irq stays 0.
3. Drive req_n[2] and req_n[6] low in the same cycle -> code=6. Ack/release -> code=2 presented. Ack/release -> pending=0.
4. Present code=1 with irq=1, then drive req_n[7]=0 -> code stays 1 until ack. After release, code=7 is presented.
5. mask_we with mask_in=8'h7F, then drive req_n[7]=0 and req_n[3]=0 -> code=3 and pending=8'h88. After ack/release, irq stays 0. Write mask 8'hFF -> irq=1 with code=7.
6. Assert rst_n=0 during ASSERT (code=4, ack=0) -> irq=0, pending=0 immediately, without waiting for a clock edge. After release, req_n[4] held low does not re-raise irq until the line goes high and falls again.
